// File: rtl/mf8_pkg.sv
// Shared definitions for the mf8 data-RAM arbiter: source encodings, defaults and the response stage record.
// Response stage record is {vld, src, we}, one entry per issued RAM access.
package mf8_pkg;

  localparam logic SRC_CORE          = 1'b0;
  localparam logic SRC_HOST          = 1'b1;
  localparam int   HOST_MAX_WAIT_DEF = 4;

  typedef struct packed {
    logic vld;
    logic src;
    logic we;
  } stage_t;

endpackage

// File: rtl/mf8_ram_resp.sv
// Response pipeline: writes complete at T+1, reads capture mem_rdata at the end of T+1 and complete at T+2.
// No backpressure; ready/ack are single-cycle pulses and read data is held until the next read of that source.
module mf8_ram_resp
  import mf8_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  stage_t     iss,
  input  logic [7:0] mem_rdata,
  output logic [7:0] core_rdata,
  output logic       core_ready,
  output logic [7:0] host_rdata,
  output logic       host_ack
);

  stage_t p1;

  logic iss_core_wr, iss_host_wr, p1_core_rd, p1_host_rd;

  always_comb begin
    iss_core_wr = iss.vld & (iss.src == SRC_CORE) & iss.we;
    iss_host_wr = iss.vld & (iss.src == SRC_HOST) & iss.we;
    p1_core_rd  = p1.vld & (p1.src == SRC_CORE) & ~p1.we;
    p1_host_rd  = p1.vld & (p1.src == SRC_HOST) & ~p1.we;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1         <= '0;
      core_ready <= 1'b0;
      host_ack   <= 1'b0;
      core_rdata <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      p1         <= iss;
      core_ready <= iss_core_wr | p1_core_rd;
      host_ack   <= iss_host_wr | p1_host_rd;
      if (p1_core_rd) core_rdata <= mem_rdata;
      if (p1_host_rd) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/mf8_ram_arb.sv
// Shares one single-port RAM between the mf8 core (priority, 1-cycle pulse-to-issue) and a held host request.
// Host issues in 0 cycles when it wins and is guaranteed a slot after HOST_MAX_WAIT denied cycles.
module mf8_ram_arb
  import mf8_pkg::*;
#(
  parameter int AW            = 10,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [15:0]   core_addr,
  input  logic          core_rd,
  input  logic          core_wr,
  input  logic [7:0]    core_wdata,
  output logic [7:0]    core_rdata,
  output logic          core_ready,
  output logic          core_ovf,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [3:0] MAX_W = 4'(HOST_MAX_WAIT);

  logic          c_pend, c_we;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_wdata;
  logic          h_busy;
  logic [3:0]    h_wait;

  logic   host_win, core_iss, core_pulse, core_take;
  stage_t iss;

  wire addr_unused = ^core_addr[15:AW];

  always_comb begin
    host_win   = host_req & ~h_busy & ((h_wait == MAX_W) | ~c_pend);
    core_iss   = c_pend & ~host_win;
    core_pulse = core_rd | core_wr;
    // The pending slot is free either when empty or when it is being issued this cycle.
    core_take  = core_pulse & (~c_pend | core_iss);

    mem_en    = host_win | core_iss;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (host_win) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (core_iss) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end

    iss     = '0;
    iss.vld = mem_en;
    iss.src = host_win ? SRC_HOST : SRC_CORE;
    iss.we  = mem_we;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      c_pend   <= 1'b0;
      c_we     <= 1'b0;
      c_addr   <= '0;
      c_wdata  <= 8'h00;
      core_ovf <= 1'b0;
    end else begin
      if (core_take) begin
        c_pend  <= 1'b1;
        c_we    <= core_wr;
        c_addr  <= core_addr[AW-1:0];
        c_wdata <= core_wdata;
      end else if (core_iss) begin
        c_pend <= 1'b0;
      end
      if (core_pulse & ~core_take) core_ovf <= 1'b1;
    end
  end

  // h_busy blocks the still-held request from re-issuing until its ack has been seen.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      h_busy <= 1'b0;
      h_wait <= 4'd0;
    end else begin
      if (host_win)      h_busy <= 1'b1;
      else if (host_ack) h_busy <= 1'b0;

      if (host_win)
        h_wait <= 4'd0;
      else if (host_req & ~h_busy & (h_wait != MAX_W))
        h_wait <= h_wait + 4'd1;
    end
  end

  mf8_ram_resp u_resp (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .iss        (iss),
    .mem_rdata  (mem_rdata),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .host_rdata (host_rdata),
    .host_ack   (host_ack)
  );

endmodule

// File: tb/tb_mf8_ram_arb.sv
// Bench for mf8_ram_arb: behavioural RAM, per-scenario tasks with inline checks, and a completion scoreboard.
module tb_mf8_ram_arb;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] core_addr = 16'h0;
  logic        core_rd = 1'b0;
  logic        core_wr = 1'b0;
  logic [7:0]  core_wdata = 8'h0;
  logic [7:0]  core_rdata;
  logic        core_ready;
  logic        core_ovf;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = 10'h0;
  logic [7:0]  host_wdata = 8'h0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
  } exp_t;

  exp_t cq[$];
  exp_t hq[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Bench-side RAM contents: unwritten locations read back pat(addr).
  function automatic logic [7:0] pat(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'h15};
  endfunction

  logic [7:0] ram    [0:1023] = '{default: 8'h00};
  logic [7:0] shadow [0:1023];

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata ^ pat(mem_addr);
      else        mem_rdata     <= ram[mem_addr] ^ pat(mem_addr);
    end
  end

  mf8_ram_arb #(.AW(10), .HOST_MAX_WAIT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready), .core_ovf(core_ovf),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge Clk);
    #1;
    core_rd = 1'b0;
    core_wr = 1'b0;
  endtask

  // Sample point of each cycle; retires completions against the scoreboard.
  task automatic sample_sb();
    exp_t e;
    #3;
    if (core_ready === 1'b1) begin
      n_checks++;
      if (cq.size() == 0) $display("FAIL sb_core_unexpected got ready=1 want no pulse");
      else begin
        e = cq.pop_front();
        if (e.rd && core_rdata !== e.d) $display("FAIL sb_core_rdata got %h want %h", core_rdata, e.d);
        else n_pass++;
      end
    end
    if (host_ack === 1'b1) begin
      n_checks++;
      if (hq.size() == 0) $display("FAIL sb_host_unexpected got ack=1 want no pulse");
      else begin
        e = hq.pop_front();
        if (e.rd && host_rdata !== e.d) $display("FAIL sb_host_rdata got %h want %h", host_rdata, e.d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    step(); sample_sb();
    n_checks++; if ({core_rdata, core_ready, core_ovf, host_ack, host_rdata} !== 19'h0) $display("FAIL reset_core_host got %h want 0", {core_rdata, core_ready, core_ovf, host_ack, host_rdata}); else n_pass++;
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 20'h0) $display("FAIL reset_mem got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata}); else n_pass++;
    step(); Reset_n = 1'b1; sample_sb();
    n_checks++; if (mem_en !== 1'b0) $display("FAIL idle_mem_en got %b want 0", mem_en); else n_pass++;
  endtask

  task automatic test_core_wr_rd();
    step(); core_wr = 1'b1; core_addr = 16'hF012; core_wdata = 8'hA5;
    shadow[10'h012] = 8'hA5; cq.push_back({1'b0, 8'h00}); sample_sb();
    n_checks++; if (mem_en !== 1'b0) $display("FAIL cwr_no_same_cycle_issue got %b want 0", mem_en); else n_pass++;
    step(); core_rd = 1'b1; core_addr = 16'h0012; cq.push_back({1'b1, shadow[10'h012]}); sample_sb();
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h012, 8'hA5}) $display("FAIL cwr_issue got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h012, 8'hA5}); else n_pass++;
    step(); sample_sb();
    n_checks++; if (core_ready !== 1'b1) $display("FAIL cwr_ready_t1 got %b want 1", core_ready); else n_pass++;
    n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h012}) $display("FAIL crd_issue got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h012}); else n_pass++;
    step(); sample_sb();
    n_checks++; if (core_ready !== 1'b0) $display("FAIL crd_ready_early got %b want 0", core_ready); else n_pass++;
    step(); sample_sb();
    n_checks++; if ({core_ready, core_rdata} !== {1'b1, 8'hA5}) $display("FAIL crd_ready_t2 got %h want %h", {core_ready, core_rdata}, {1'b1, 8'hA5}); else n_pass++;
  endtask

  task automatic test_host_rw();
    step(); host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 8'h5C;
    shadow[10'h3FF] = 8'h5C; hq.push_back({1'b0, 8'h00}); sample_sb();
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h3FF, 8'h5C}) $display("FAIL hwr_issue got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h3FF, 8'h5C}); else n_pass++;
    step(); sample_sb();
    n_checks++; if ({host_ack, mem_en} !== 2'b10) $display("FAIL hwr_ack_t1 got %b want 10", {host_ack, mem_en}); else n_pass++;
    step(); host_req = 1'b0; sample_sb();
    step(); host_req = 1'b1; host_we = 1'b0; hq.push_back({1'b1, shadow[10'h3FF]}); sample_sb();
    n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h3FF}) $display("FAIL hrd_issue got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h3FF}); else n_pass++;
    step(); sample_sb();
    n_checks++; if ({mem_en, host_ack} !== 2'b00) $display("FAIL hrd_no_reissue got %b want 00", {mem_en, host_ack}); else n_pass++;
    step(); sample_sb();
    n_checks++; if ({host_ack, host_rdata} !== {1'b1, 8'h5C}) $display("FAIL hrd_ack_t2 got %h want %h", {host_ack, host_rdata}, {1'b1, 8'h5C}); else n_pass++;
    step(); host_req = 1'b0; sample_sb();
    n_checks++; if (mem_en !== 1'b0) $display("FAIL hrd_idle_after got %b want 0", mem_en); else n_pass++;
  endtask

  // Core pulses cycles 0..4; host holds a read from cycle 1; with drop=1 the core also pulses in the host-win cycle.
  task automatic test_starvation(input bit drop);
    logic [9:0] ea;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k <= 4 || (drop && k == 5)) begin
        core_rd = 1'b1;
        core_addr = 16'hFD00 + 16'(k);
        if (k <= 4) cq.push_back({1'b1, shadow[10'h100 + 10'(k)]});
      end
      if (k == 1) begin
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h200;
        hq.push_back({1'b1, shadow[10'h200]});
      end
      sample_sb();
      if (k >= 1 && k <= 4) begin
        ea = 10'h100 + 10'(k - 1);
        n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, ea}) $display("FAIL starve_core_slot%0d got %h want %h", k, {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, ea}); else n_pass++;
      end
      if (k == 5) begin
        n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h200}) $display("FAIL starve_host_win got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h200}); else n_pass++;
      end
      if (k == 6) begin
        n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h104}) $display("FAIL starve_core_next got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h104}); else n_pass++;
      end
      if (k == 7) begin
        n_checks++; if ({mem_en, host_ack} !== 2'b01) $display("FAIL starve_host_ack got %b want 01", {mem_en, host_ack}); else n_pass++;
      end
    end
    step(); host_req = 1'b0; sample_sb();
    n_checks++; if (core_ovf !== drop) $display("FAIL starve_ovf got %b want %b", core_ovf, drop); else n_pass++;
    repeat (2) begin step(); sample_sb(); end
  endtask

  task automatic test_collision();
    step(); core_wr = 1'b1; core_addr = 16'h0050; core_wdata = 8'h77;
    shadow[10'h050] = 8'h77; cq.push_back({1'b0, 8'h00}); sample_sb();
    step(); host_req = 1'b1; host_we = 1'b0; host_addr = 10'h050;
    hq.push_back({1'b1, shadow[10'h050]}); sample_sb();
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h050, 8'h77}) $display("FAIL coll_core_first got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h050, 8'h77}); else n_pass++;
    step(); sample_sb();
    n_checks++; if ({mem_en, mem_we, mem_addr, core_ready} !== {1'b1, 1'b0, 10'h050, 1'b1}) $display("FAIL coll_host_next got %h want %h", {mem_en, mem_we, mem_addr, core_ready}, {1'b1, 1'b0, 10'h050, 1'b1}); else n_pass++;
    step(); sample_sb();
    step(); sample_sb();
    n_checks++; if ({host_ack, host_rdata} !== {1'b1, 8'h77}) $display("FAIL coll_host_ack got %h want %h", {host_ack, host_rdata}, {1'b1, 8'h77}); else n_pass++;
    step(); host_req = 1'b0; sample_sb();
    n_checks++; if (core_ovf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", core_ovf); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    step(); core_rd = 1'b1; core_addr = 16'h0012; sample_sb();
    step(); sample_sb();
    n_checks++; if ({mem_en, mem_addr} !== {1'b1, 10'h012}) $display("FAIL rst_rd_issue got %h want %h", {mem_en, mem_addr}, {1'b1, 10'h012}); else n_pass++;
    step(); Reset_n = 1'b0; sample_sb();
    n_checks++; if ({core_ready, core_rdata, core_ovf, host_ack, host_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== 39'h0) $display("FAIL rst_mid_outputs got %h want 0", {core_ready, core_rdata, core_ovf, host_ack, host_rdata, mem_en, mem_we, mem_addr, mem_wdata}); else n_pass++;
    step(); sample_sb();
    step(); Reset_n = 1'b1; sample_sb();
    n_checks++; if (core_ready !== 1'b0) $display("FAIL rst_no_ready got %b want 0", core_ready); else n_pass++;
    step(); core_rd = 1'b1; core_addr = 16'h0012; cq.push_back({1'b1, shadow[10'h012]}); sample_sb();
    step(); sample_sb();
    step(); sample_sb();
    step(); sample_sb();
    n_checks++; if ({core_ready, core_rdata} !== {1'b1, 8'hA5}) $display("FAIL rst_fresh_read got %h want %h", {core_ready, core_rdata}, {1'b1, 8'hA5}); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = pat(10'(i));
    test_reset();
    test_core_wr_rd();
    test_host_rw();
    test_starvation(1'b0);
    test_starvation(1'b1);
    test_collision();
    test_reset_mid_read();
    repeat (3) begin step(); sample_sb(); end
    n_checks++; if (cq.size() != 0) $display("FAIL core_pending_left got %0d want 0", cq.size()); else n_pass++;
    n_checks++; if (hq.size() != 0) $display("FAIL host_pending_left got %0d want 0", hq.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mf8_ram_arb.md
# mf8_ram_arb

Arbiter and sequencer for the mf8 data RAM. It shares one synchronous single-port RAM between the mf8 core's load/store port (pulsed `ram_read`/`ram_write`, address `ZZ`, completion `ram_ready`) and a host-side master, such as a RISC-V bus bridge or debug loader. The core has priority, and a bounded-wait counter guarantees host progress. The block sits between `mf8_core` and the RAM macro, at the engine top level.

## Interface
Parameters:
- `AW`, default 10: RAM address width; the upper address bits are ignored.
- `HOST_MAX_WAIT`, default 4: number of consecutive denied host cycles before the host outranks the core (range 1..15).

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `core_addr` in 16: core address (`ZZ`).
- `core_rd` in 1: one-cycle read request pulse.
- `core_wr` in 1: one-cycle write request pulse.
- `core_wdata` in 8: write data, sampled with the `core_wr` pulse.
- `core_rdata` out 8: read data, held until the next core read completes.
- `core_ready` out 1: one-cycle completion pulse (to `ram_ready`).
- `core_ovf` out 1: sticky flag; a core request arrived while one was still pending.
- `host_req` in 1: level request; held with `host_we`, `host_addr` and `host_wdata` stable until acknowledged.
- `host_we` in 1: host write enable.
- `host_addr` in AW: host address.
- `host_wdata` in 8: host write data.
- `host_ack` out 1: one-cycle pulse when the host access completes.
- `host_rdata` out 8: host read data, valid in the `host_ack` cycle and held afterwards.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out AW: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid in the cycle after issue.

## Operation
- **Core pending register.** A `core_rd` or `core_wr` pulse latches `{we, addr[AW-1:0], wdata}` and sets `c_pend`.
  - If both pulses arrive together, it is treated as a write.
  - A pulse while `c_pend=1` and not issued that cycle is dropped and sets `core_ovf`, which stays set until reset.
- **Issue decision.** Made every cycle; at most one RAM access is issued per cycle.
  - `host_win = host_req & !h_busy & (h_wait == HOST_MAX_WAIT | !c_pend)`.
  - The core issues if `c_pend & !host_win`.
  - Issue drives `mem_en=1`, `mem_we`, `mem_addr` and `mem_wdata` combinationally from the winning source's latched or stable values.
- **Host flow.** `h_busy` is set from issue until `host_ack`, which prevents the held `host_req` from re-issuing.
- **Wait counter.** `h_wait` (4 bits) increments each cycle that `host_req & !h_busy` holds without a host issue, saturates at `HOST_MAX_WAIT`, and clears on host issue.
- **Read/write pipeline** (one pipeline stage records `{src, we}`):
  - Core write: `core_ready` pulses at T+1.
  - Core read: `mem_rdata` is captured into `core_rdata` at the end of T+1, and `core_ready` pulses at T+2.
  - Host read: `host_rdata <= mem_rdata` at the end of T+1, and `host_ack` pulses at T+2.
  - Host write: `host_ack` pulses at T+1.
- **Ordering.** Accesses execute in issue order, so read-after-write to the same address returns the new data.
- **Idle.** With no request pending, `mem_en=0`. `mem_addr` and `mem_wdata` are don't-care and are driven 0.

## Timing
- **Reset values:** all outputs 0; `c_pend=0`, `h_busy=0`, `h_wait=0`, pipeline stages invalid, `core_ovf=0`.
- **Reset mid-operation:** in-flight accesses are abandoned, and no ack or ready pulses follow.
- **Latency from request to issue:** core 1 cycle (pulse at T-1, issue at T); host 0 cycles if it wins.
- **Throughput:** one access per cycle. The core can re-pulse in the cycle after its issue; a pulse in the issue cycle itself is also accepted as the new pending request.
- **Simultaneous core and host requests with `h_wait < HOST_MAX_WAIT`:** the core wins.
- **Host starvation:** under continuous core traffic, the host issues within `HOST_MAX_WAIT+1` cycles of `host_req`.
- **Core under host priority:** the core waits at most 1 slot, because `h_wait` clears on host issue.

## Structure
- A shared package `mf8_pkg` holds the source encoding constants (`SRC_CORE=0`, `SRC_HOST=1`) and the default `HOST_MAX_WAIT`.
- There is one natural sub-module, `mf8_ram_resp`: the T+1/T+2 response pipeline, which handles data capture and the ready/ack pulse generation.
- The arbitration, pending register and wait counter stay in `mf8_ram_arb`.

## Test plan
- **Core write then read:** `core_wr` addr 0x012 data 0xA5, then `core_rd` 0x012 → `mem_we=1`, `mem_addr=0x012`; write `core_ready` at T+1; read `core_ready` at T+2 with `core_rdata=0xA5`.
- **Host read alone:** `host_req` `host_we=0` addr 0x3FF (RAM holds 0x5C) → issue the same cycle, `host_ack` at T+2, `host_rdata=0x5C`, no second issue while the request is held.
- **Starvation:** core pulses every cycle and `host_req` is held, `HOST_MAX_WAIT=4` → host issues on its 5th cycle, the core's pending request issues the next cycle, and `core_ovf` stays 0.
- **Collision:** core and host request in the same cycle with `h_wait=0` → core issues first and the host issues the next cycle; both complete with correct data.
- **Overflow:** two `core_rd` pulses in consecutive cycles while the host holds priority → second pulse dropped, `core_ovf=1` sticky.
- **Reset mid-read:** `Reset_n` low at T+1 of a core read → `core_ready` never pulses, all outputs 0; after release a fresh read works.
